refill_forwarder: RTL and testbench
===================================

# refill_forwarder

Instruction-cache refill stage directly downstream of the memory controller. Captures the missing fetch address from the miss handler, watches the block assembling in the memory controller, and forwards the critical instruction word to fetch as soon as its pair lands (early restart). When the full 320-bit block is received, it issues a single-cycle line write to the cache data/tag arrays, then returns to idle.

## Interface
Parameters:
- ADDR_WIDTH, 16, word address width
- WORD_WIDTH, 20, instruction word width
- NUM_WORDS_P_BLOCK, 16, words per block; offset = addr[3:0]
- BLOCK_DATA_WIDTH, 320, NUM_WORDS_P_BLOCK*WORD_WIDTH

Ports:
- clk  in  1  clock; one clock domain, all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_halt  in  1  freezes all state; masks o_fwd_valid and o_line_wr_en
- i_miss_addr  in  16  missing fetch word address
- i_miss_valid  in  1  miss request; accepted when i_miss_valid & o_miss_ready
- o_miss_ready  out  1  state==IDLE & ~i_halt
- i_mem_block_data  in  320  block from memory controller; word k at [20k+19:20k]
- i_mem_num_words_rcvd  in  5  words landed so far (0,2,..,16)
- i_mem_data_received  in  1  one-cycle pulse: whole block present
- o_fwd_instr  out  20  forwarded instruction word
- o_fwd_addr  out  16  address of o_fwd_instr
- o_fwd_valid  out  1  forward valid; held until i_fwd_ready
- i_fwd_ready  in  1  fetch accepts forwarded word
- o_line_wr_en  out  1  one-cycle line write strobe
- o_line_wr_addr  out  12  block address (miss addr[15:4])
- o_line_wr_data  out  320  captured block
- o_busy  out  1  state!=IDLE

## Operation
- States: IDLE, WAIT_WORD, FWD, DRAIN.
- IDLE: on accept, latch addr into r_addr, r_fwd_ptr<=addr[3:0], clear r_line_done; ->WAIT_WORD.
- Word k available: r_line_done ? 1 : (i_mem_num_words_rcvd > k).
- WAIT_WORD: when word r_fwd_ptr available, load o_fwd_instr/o_fwd_addr from live block (or line register if r_line_done), set o_fwd_valid; ->FWD.
- FWD: on o_fwd_valid & i_fwd_ready drop valid; if no further word to forward ->DRAIN, else (stream mode) r_fwd_ptr+1, ->WAIT_WORD.
- Independently in any non-IDLE state: i_mem_data_received -> o_line_wr_data<=i_mem_block_data, o_line_wr_addr<=r_addr[15:4], o_line_wr_en=1 next cycle for exactly one cycle, r_line_done<=1.
- DRAIN: wait for r_line_done and strobe completed; ->IDLE.
- Simultaneous critical-word arrival and i_mem_data_received (count jumps to 16): both forward load and line capture occur same cycle.
- Forwarded data is always taken from register, never combinationally from memory-controller port.
- i_mem_data_received in IDLE ignored.
- rst mid-refill: all state to IDLE, pending forward and write dropped, no strobe.

## Timing
- Reset values: o_fwd_valid 0, o_fwd_instr 0, o_fwd_addr 0, o_line_wr_en 0, o_line_wr_addr 0, o_line_wr_data 0, o_busy 0, o_miss_ready 1 (if ~i_halt).
- Miss accept cycle N -> o_busy at N+1.
- Word available at cycle M (in WAIT_WORD) -> o_fwd_valid at M+1.
- i_mem_data_received at cycle P -> o_line_wr_en high at P+1 only.
- Earliest new miss: cycle after return to IDLE.
- i_halt: no state/register updates; o_fwd_valid and o_line_wr_en forced 0 while high, reasserted after halt if still pending (strobe fires once, after halt).

## Configuration
- REFILL_STREAM_EN defined: after critical word, continue forwarding offset+1..15 in order, each as it becomes available, one per i_fwd_ready handshake; stop at word 15 (no wrap); ->DRAIN after word 15 accepted.
- Undefined: only the critical word forwarded; FWD ->DRAIN after its handshake.

## Test plan
- Miss 0x1235 (offset 5), pairs arrive every 2 cycles, i_fwd_ready=1 -> o_fwd_valid one cycle after count reaches 6, o_fwd_addr 0x1235, word 5 data; o_line_wr_en one cycle after received pulse, wr_addr 0x123.
- Offset 15, received pulse with count=16 same cycle -> forward and line strobe both at next cycle; o_line_wr_data equals full block.
- i_fwd_ready held 0 for 20 cycles after valid -> o_fwd_instr/addr stable, line write still fires once, o_busy until handshake, then IDLE.
- i_halt asserted across received pulse+1 -> no strobe while halted, exactly one strobe cycle after release; no state change during halt.
- rst pulsed in WAIT_WORD with count=4 -> all outputs reset values next cycle; later received pulse ignored.
- REFILL_STREAM_EN, miss offset 12 -> words 12,13,14,15 forwarded in order with addresses +0..+3, then IDLE; without macro only word 12.

Source files
------------

// File: rtl/refill_forwarder_if.sv
// rtl/refill_forwarder_if.sv - miss/memory/forward/line-write bundle for refill_forwarder
interface refill_forwarder_if #(
   parameter int ADDR_WIDTH        = 16,
   parameter int WORD_WIDTH        = 20,
   parameter int NUM_WORDS_P_BLOCK = 16,
   parameter int BLOCK_DATA_WIDTH  = NUM_WORDS_P_BLOCK * WORD_WIDTH
);
   localparam int OFF_W = $clog2(NUM_WORDS_P_BLOCK);

   logic                          i_halt;
   logic [ADDR_WIDTH-1:0]         i_miss_addr;
   logic                          i_miss_valid;
   logic                          o_miss_ready;
   logic [BLOCK_DATA_WIDTH-1:0]   i_mem_block_data;
   logic [OFF_W:0]                i_mem_num_words_rcvd;
   logic                          i_mem_data_received;
   logic [WORD_WIDTH-1:0]         o_fwd_instr;
   logic [ADDR_WIDTH-1:0]         o_fwd_addr;
   logic                          o_fwd_valid;
   logic                          i_fwd_ready;
   logic                          o_line_wr_en;
   logic [ADDR_WIDTH-OFF_W-1:0]   o_line_wr_addr;
   logic [BLOCK_DATA_WIDTH-1:0]   o_line_wr_data;
   logic                          o_busy;

   modport master (
      output i_halt, i_miss_addr, i_miss_valid, i_mem_block_data,
             i_mem_num_words_rcvd, i_mem_data_received, i_fwd_ready,
      input  o_miss_ready, o_fwd_instr, o_fwd_addr, o_fwd_valid,
             o_line_wr_en, o_line_wr_addr, o_line_wr_data, o_busy
   );

   modport slave (
      input  i_halt, i_miss_addr, i_miss_valid, i_mem_block_data,
             i_mem_num_words_rcvd, i_mem_data_received, i_fwd_ready,
      output o_miss_ready, o_fwd_instr, o_fwd_addr, o_fwd_valid,
             o_line_wr_en, o_line_wr_addr, o_line_wr_data, o_busy
   );
endinterface

// File: rtl/refill_forwarder.sv
// rtl/refill_forwarder.sv - I-cache refill stage with critical-word early restart
// Optional REFILL_STREAM_EN: keep forwarding offset+1..last word after the critical word.
module refill_forwarder #(
   parameter int ADDR_WIDTH        = 16,
   parameter int WORD_WIDTH        = 20,
   parameter int NUM_WORDS_P_BLOCK = 16,
   parameter int BLOCK_DATA_WIDTH  = NUM_WORDS_P_BLOCK * WORD_WIDTH
) (
   input logic              clk,
   input logic              rst,
   refill_forwarder_if.slave bus
);
   localparam int OFF_W = $clog2(NUM_WORDS_P_BLOCK);
   localparam int BLK_W = ADDR_WIDTH - OFF_W;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_WORD = 2'd1;
   localparam logic [1:0] S_FWD       = 2'd2;
   localparam logic [1:0] S_DRAIN     = 2'd3;

`ifdef REFILL_STREAM_EN
   localparam logic [OFF_W-1:0] LAST_PTR = OFF_W'(NUM_WORDS_P_BLOCK - 1);
`endif

   logic [1:0]                  state_q,        state_d;
   logic [BLK_W-1:0]            blk_addr_q,     blk_addr_d;
   logic [OFF_W-1:0]            fwd_ptr_q,      fwd_ptr_d;
   logic                        line_done_q,    line_done_d;
   logic                        fwd_valid_q,    fwd_valid_d;
   logic [WORD_WIDTH-1:0]       fwd_instr_q,    fwd_instr_d;
   logic [ADDR_WIDTH-1:0]       fwd_addr_q,     fwd_addr_d;
   logic                        wr_pend_q,      wr_pend_d;
   logic [BLK_W-1:0]            wr_addr_q,      wr_addr_d;
   logic [BLOCK_DATA_WIDTH-1:0] wr_data_q,      wr_data_d;

   logic                        word_avail;
   logic [WORD_WIDTH-1:0]       sel_word;
   int                          word_lsb;

   always_comb begin
      state_d     = state_q;
      blk_addr_d  = blk_addr_q;
      fwd_ptr_d   = fwd_ptr_q;
      line_done_d = line_done_q;
      fwd_valid_d = fwd_valid_q;
      fwd_instr_d = fwd_instr_q;
      fwd_addr_d  = fwd_addr_q;
      wr_pend_d   = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      // Once the line is captured the live port may move on, so read the copy.
      word_lsb   = int'(fwd_ptr_q) * WORD_WIDTH;
      word_avail = line_done_q | (bus.i_mem_num_words_rcvd > {1'b0, fwd_ptr_q});
      sel_word   = line_done_q ? wr_data_q[word_lsb +: WORD_WIDTH]
                               : bus.i_mem_block_data[word_lsb +: WORD_WIDTH];

      if (state_q != S_IDLE && bus.i_mem_data_received) begin
         wr_data_d   = bus.i_mem_block_data;
         wr_addr_d   = blk_addr_q;
         wr_pend_d   = 1'b1;
         line_done_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.i_miss_valid) begin
               blk_addr_d  = bus.i_miss_addr[ADDR_WIDTH-1:OFF_W];
               fwd_ptr_d   = bus.i_miss_addr[OFF_W-1:0];
               line_done_d = 1'b0;
               state_d     = S_WAIT_WORD;
            end
         end
         S_WAIT_WORD: begin
            if (word_avail) begin
               fwd_instr_d = sel_word;
               fwd_addr_d  = {blk_addr_q, fwd_ptr_q};
               fwd_valid_d = 1'b1;
               state_d     = S_FWD;
            end
         end
         S_FWD: begin
            if (fwd_valid_q && bus.i_fwd_ready) begin
               fwd_valid_d = 1'b0;
`ifdef REFILL_STREAM_EN
               if (fwd_ptr_q == LAST_PTR) begin
                  state_d = S_DRAIN;
               end else begin
                  fwd_ptr_d = fwd_ptr_q + 1'b1;
                  state_d   = S_WAIT_WORD;
               end
`else
               state_d = S_DRAIN;
`endif
            end
         end
         default: begin
            if (line_done_q && !wr_pend_q) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Halt freezes every register, so a pending strobe or forward survives it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         blk_addr_q  <= '0;
         fwd_ptr_q   <= '0;
         line_done_q <= 1'b0;
         fwd_valid_q <= 1'b0;
         fwd_instr_q <= '0;
         fwd_addr_q  <= '0;
         wr_pend_q   <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else if (!bus.i_halt) begin
         state_q     <= state_d;
         blk_addr_q  <= blk_addr_d;
         fwd_ptr_q   <= fwd_ptr_d;
         line_done_q <= line_done_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_instr_q <= fwd_instr_d;
         fwd_addr_q  <= fwd_addr_d;
         wr_pend_q   <= wr_pend_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign bus.o_miss_ready   = (state_q == S_IDLE) & ~bus.i_halt;
   assign bus.o_busy         = (state_q != S_IDLE);
   assign bus.o_fwd_valid    = fwd_valid_q & ~bus.i_halt;
   assign bus.o_fwd_instr    = fwd_instr_q;
   assign bus.o_fwd_addr     = fwd_addr_q;
   assign bus.o_line_wr_en   = wr_pend_q & ~bus.i_halt;
   assign bus.o_line_wr_addr = wr_addr_q;
   assign bus.o_line_wr_data = wr_data_q;
endmodule

// File: tb/tb_refill_forwarder.sv
// tb/tb_refill_forwarder.sv - directed self-checking bench for refill_forwarder
module tb_refill_forwarder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   strobes;
   int   nf;
   int   exp_nf;
   logic [319:0] blk;

   refill_forwarder_if bus ();

   refill_forwarder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] w(input int seed, input int k);
      return 20'((seed << 12) | (k * 257));
   endfunction

   function automatic logic [319:0] mk(input int seed);
      logic [319:0] b;
      for (int k = 0; k < 16; k++) b[k*20 +: 20] = w(seed, k);
      return b;
   endfunction

   task automatic miss(input logic [15:0] a);
      bus.i_mem_num_words_rcvd = 5'd0;
      bus.i_miss_addr  = a;
      bus.i_miss_valid = 1'b1;
      tick();
      bus.i_miss_valid = 1'b0;
   endtask

   initial begin
      bus.i_halt = 0; bus.i_miss_addr = 0; bus.i_miss_valid = 0;
      bus.i_mem_block_data = '0; bus.i_mem_num_words_rcvd = 0;
      bus.i_mem_data_received = 0; bus.i_fwd_ready = 1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", bus.o_fwd_valid, 0);
      chk("rst_instr", bus.o_fwd_instr, 0);
      chk("rst_addr", bus.o_fwd_addr, 0);
      chk("rst_wr_en", bus.o_line_wr_en, 0);
      chk("rst_wr_addr", bus.o_line_wr_addr, 0);
      chk("rst_wr_data", bus.o_line_wr_data, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_ready", bus.o_miss_ready, 1);

      // Critical word 5 of miss 0x1235, pairs every two cycles
      blk = mk(1); bus.i_mem_block_data = blk;
      miss(16'h1235);
      chk("t1_busy", bus.o_busy, 1);
      chk("t1_ready", bus.o_miss_ready, 0);
      bus.i_mem_num_words_rcvd = 2; tick(); tick();
      chk("t1_valid_c2", bus.o_fwd_valid, 0);
      bus.i_mem_num_words_rcvd = 4; tick(); tick();
      chk("t1_valid_c4", bus.o_fwd_valid, 0);
      bus.i_mem_num_words_rcvd = 6; tick();
      chk("t1_valid", bus.o_fwd_valid, 1);
      chk("t1_addr", bus.o_fwd_addr, 16'h1235);
      chk("t1_instr", bus.o_fwd_instr, w(1, 5));
      tick();
      chk("t1_valid_drop", bus.o_fwd_valid, 0);
      for (int c = 8; c < 16; c += 2) begin
         bus.i_mem_num_words_rcvd = 5'(c); tick(); tick();
      end
      bus.i_mem_num_words_rcvd = 16; bus.i_mem_data_received = 1; tick();
      bus.i_mem_data_received = 0;
      chk("t1_wr_en", bus.o_line_wr_en, 1);
      chk("t1_wr_addr", bus.o_line_wr_addr, 12'h123);
      chk("t1_wr_data", bus.o_line_wr_data, blk);
      tick();
      chk("t1_wr_en_off", bus.o_line_wr_en, 0);
      chk("t1_busy_drain", bus.o_busy, 1);
      tick();
      chk("t1_idle", bus.o_busy, 0);
      chk("t1_ready_back", bus.o_miss_ready, 1);

      // Offset 15: critical word and whole block land together
      blk = mk(2); bus.i_mem_block_data = blk;
      miss(16'h00AF);
      bus.i_mem_num_words_rcvd = 14; tick(); tick();
      chk("t2_valid_c14", bus.o_fwd_valid, 0);
      bus.i_mem_num_words_rcvd = 16; bus.i_mem_data_received = 1; tick();
      bus.i_mem_data_received = 0;
      chk("t2_valid", bus.o_fwd_valid, 1);
      chk("t2_instr", bus.o_fwd_instr, w(2, 15));
      chk("t2_addr", bus.o_fwd_addr, 16'h00AF);
      chk("t2_wr_en", bus.o_line_wr_en, 1);
      chk("t2_wr_addr", bus.o_line_wr_addr, 12'h00A);
      chk("t2_wr_data", bus.o_line_wr_data, blk);
      tick();
      chk("t2_valid_drop", bus.o_fwd_valid, 0);
      chk("t2_wr_en_off", bus.o_line_wr_en, 0);
      chk("t2_busy", bus.o_busy, 1);
      tick();
      chk("t2_idle", bus.o_busy, 0);

      // Fetch stalls 20 cycles; forward held stable, line write fires once
      blk = mk(3); bus.i_mem_block_data = blk; bus.i_fwd_ready = 0;
      miss(16'h4562);
      bus.i_mem_num_words_rcvd = 4; tick();
      chk("t3_valid", bus.o_fwd_valid, 1);
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            bus.i_mem_num_words_rcvd = 16; bus.i_mem_data_received = 1;
         end else begin
            bus.i_mem_data_received = 0;
         end
         tick();
         if (bus.o_line_wr_en) strobes++;
         chk("t3_instr_hold", bus.o_fwd_instr, w(3, 2));
         chk("t3_addr_hold", bus.o_fwd_addr, 16'h4562);
         chk("t3_valid_hold", bus.o_fwd_valid, 1);
      end
      chk("t3_strobes", strobes, 1);
      chk("t3_wr_data", bus.o_line_wr_data, blk);
      chk("t3_busy", bus.o_busy, 1);
      bus.i_fwd_ready = 1; tick();
      chk("t3_valid_drop", bus.o_fwd_valid, 0);
      tick();
      chk("t3_idle", bus.o_busy, 0);

      // Halt masks a pending forward and the line strobe, which fires once after release
      blk = mk(4); bus.i_mem_block_data = blk;
      miss(16'h7778);
      bus.i_mem_num_words_rcvd = 10; tick();
      chk("t4_valid", bus.o_fwd_valid, 1);
      bus.i_halt = 1; #1;
      chk("t4_valid_mask", bus.o_fwd_valid, 0);
      chk("t4_ready_mask", bus.o_miss_ready, 0);
      tick();
      chk("t4_valid_mask2", bus.o_fwd_valid, 0);
      bus.i_halt = 0; #1;
      chk("t4_valid_back", bus.o_fwd_valid, 1);
      chk("t4_instr", bus.o_fwd_instr, w(4, 8));
      tick();
      chk("t4_valid_drop", bus.o_fwd_valid, 0);
      bus.i_mem_num_words_rcvd = 16; bus.i_mem_data_received = 1; tick();
      bus.i_mem_data_received = 0; bus.i_halt = 1; #1;
      chk("t4_wr_mask", bus.o_line_wr_en, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_wr_mask_hold", bus.o_line_wr_en, 0);
         chk("t4_busy_hold", bus.o_busy, 1);
      end
      bus.i_halt = 0; #1;
      chk("t4_wr_en", bus.o_line_wr_en, 1);
      chk("t4_wr_addr", bus.o_line_wr_addr, 12'h777);
      tick();
      chk("t4_wr_en_off", bus.o_line_wr_en, 0);
      chk("t4_busy", bus.o_busy, 1);
      tick();
      chk("t4_idle", bus.o_busy, 0);

      // Reset mid-refill drops everything; a late received pulse is ignored
      blk = mk(5); bus.i_mem_block_data = blk;
      miss(16'h2229);
      bus.i_mem_num_words_rcvd = 4; tick(); tick();
      chk("t5_busy", bus.o_busy, 1);
      chk("t5_valid", bus.o_fwd_valid, 0);
      rst = 1; tick(); rst = 0;
      chk("t5_rst_valid", bus.o_fwd_valid, 0);
      chk("t5_rst_instr", bus.o_fwd_instr, 0);
      chk("t5_rst_addr", bus.o_fwd_addr, 0);
      chk("t5_rst_wr_en", bus.o_line_wr_en, 0);
      chk("t5_rst_wr_addr", bus.o_line_wr_addr, 0);
      chk("t5_rst_wr_data", bus.o_line_wr_data, 0);
      chk("t5_rst_busy", bus.o_busy, 0);
      chk("t5_rst_ready", bus.o_miss_ready, 1);
      bus.i_mem_num_words_rcvd = 16; bus.i_mem_data_received = 1; tick();
      bus.i_mem_data_received = 0;
      chk("t5_idle_wr_en", bus.o_line_wr_en, 0);
      chk("t5_idle_wr_data", bus.o_line_wr_data, 0);
      chk("t5_idle_busy", bus.o_busy, 0);

      // Offset 12: stream mode forwards 12..15, otherwise only 12
      blk = mk(6); bus.i_mem_block_data = blk;
      miss(16'h3C3C);
      bus.i_mem_num_words_rcvd = 16; bus.i_mem_data_received = 1; tick();
      bus.i_mem_data_received = 0;
      nf = 0; strobes = 0;
      for (int i = 0; i < 60; i++) begin
         if (bus.o_line_wr_en) strobes++;
         if (bus.o_fwd_valid) begin
            chk("t6_addr", bus.o_fwd_addr, 16'h3C3C + 16'(nf));
            chk("t6_instr", bus.o_fwd_instr, w(6, 12 + nf));
            nf++;
         end
         if (!bus.o_busy) break;
         tick();
      end
`ifdef REFILL_STREAM_EN
      exp_nf = 4;
`else
      exp_nf = 1;
`endif
      chk("t6_count", nf, exp_nf);
      chk("t6_strobes", strobes, 1);
      chk("t6_idle", bus.o_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
